// File: rtl/pager_tx_if.sv
// Handshake and serial-line bundle between a page source (master) and pager_tx (slave).
interface pager_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              x;
  logic              busy;
  logic              frame_done;

  modport master (output din, din_valid, input din_ready, x, busy, frame_done);
  modport slave  (input din, din_valid, output din_ready, x, busy, frame_done);
endinterface

// File: rtl/pager_tx.sv
// pager_tx: serial page transmitter; preamble, MSB-first code, optional parity, idle gap.
// Define PAGER_TX_PARITY_EN to append an even-parity bit after the data LSB.
//
// state  | meaning
// S_IDLE | waiting for a code, din_ready high
// S_PRE  | shifting out the preamble, MSB first
// S_DATA | shifting out the latched code, MSB first
// S_PAR  | even-parity bit (only with PAGER_TX_PARITY_EN)
// S_GAP  | idle zeros between frames
module pager_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b0011,
  parameter int                GAP      = 2
) (
  input logic       clk,
  input logic       rst,
  pager_tx_if.slave bus
);

  localparam int MAX_A = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int MAX_V = (MAX_A > GAP) ? MAX_A : GAP;
  localparam int CNT_W = $clog2(MAX_V + 1);
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_W - 1);
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
`ifdef PAGER_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [PRE_W-1:0]  pre_sh;
  logic [CNT_W-1:0]  cnt;
  logic              x_q;
  logic              busy_q;
  logic              done_q;

  assign bus.din_ready  = (state == S_IDLE);
  assign bus.x          = x_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

  // Outputs lag the state by one cycle: bit k appears the cycle after its state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      shreg  <= '0;
      pre_sh <= '0;
      cnt    <= '0;
      x_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      x_q    <= 1'b0;
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.din_valid) begin
            shreg  <= bus.din;
            pre_sh <= PREAMBLE;
            cnt    <= PRE_LD;
            busy_q <= 1'b1;
            state  <= S_PRE;
          end
        end
        S_PRE: begin
          x_q    <= pre_sh[PRE_W-1];
          pre_sh <= pre_sh << 1;
          if (cnt == '0) begin
            cnt   <= DATA_LD;
            state <= S_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          x_q   <= shreg[DATA_W-1];
          // rotate so the full code is still intact for the parity bit
          shreg <= (shreg << 1) | (shreg >> (DATA_W - 1));
          if (cnt == '0) begin
`ifdef PAGER_TX_PARITY_EN
            cnt   <= '0;
            state <= S_PAR;
`else
            done_q <= 1'b1;
            if (GAP == 0) begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt   <= GAP_LD;
              state <= S_GAP;
            end
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef PAGER_TX_PARITY_EN
        S_PAR: begin
          x_q    <= ^shreg;
          done_q <= 1'b1;
          if (GAP == 0) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt   <= GAP_LD;
            state <= S_GAP;
          end
        end
`endif
        S_GAP: begin
          if (cnt == '0) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pager_tx.sv
// Directed bench for pager_tx: default GAP=2 instance plus a GAP=0 instance.
module tb_pager_tx;

`ifdef PAGER_TX_PARITY_EN
  localparam int PB = 1;
  localparam logic [15:0] V_A5 = 16'b0_0011_1010_0101_0_00;
  localparam logic [15:0] V_07 = 16'b0_0011_0000_0111_1_00;
  localparam logic [15:0] V_3C = 16'b0_0011_0011_1100_0_00;
  localparam logic [15:0] V_FF = 16'b0_0011_1111_1111_0_00;
  localparam logic [31:0] V_G0 = 32'b0000_0011_1010_0101_0_0_0011_0011_1100_0_0;
`else
  localparam int PB = 0;
  localparam logic [15:0] V_A5 = 16'b00_0011_1010_0101_00;
  localparam logic [15:0] V_07 = 16'b00_0011_0000_0111_00;
  localparam logic [15:0] V_3C = 16'b00_0011_0011_1100_00;
  localparam logic [15:0] V_FF = 16'b00_0011_1111_1111_00;
  localparam logic [31:0] V_G0 = 32'b000000_0011_1010_0101_0_0011_0011_1100_0;
`endif
  localparam int L  = 12 + PB;
  localparam int NB = L + 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  pager_tx_if #(.DATA_W(8)) m_if ();
  pager_tx_if #(.DATA_W(8)) g_if ();

  pager_tx u_dut (.clk(clk), .rst(rst), .bus(m_if));
  pager_tx #(.GAP(0)) u_g0 (.clk(clk), .rst(rst), .bus(g_if));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(m_if.x), 0);
    chk({tag, "_rdy"}, 32'(m_if.din_ready), 1);
    chk({tag, "_busy"}, 32'(m_if.busy), 0);
    chk({tag, "_done"}, 32'(m_if.frame_done), 0);
  endtask

  // Entered just after the handshake edge; walks cycles 0..nbits.
  task automatic capture(input string tag, input logic [15:0] exp, input int nbits,
                         input int chg_at, input logic [7:0] chg_val, input bit drop);
    @(negedge clk);
    if (drop) m_if.din_valid = 1'b0;
    chk({tag, "_busy0"}, 32'(m_if.busy), 1);
    chk({tag, "_rdy0"}, 32'(m_if.din_ready), 0);
    chk({tag, "_x0"}, 32'(m_if.x), 0);
    for (int k = 0; k < nbits; k++) begin
      if (k == chg_at) m_if.din = chg_val;
      @(negedge clk);
      chk($sformatf("%s_x%0d", tag, k), 32'(m_if.x), 32'(exp[nbits-1-k]));
      chk($sformatf("%s_done%0d", tag, k), 32'(m_if.frame_done), 32'(k == L - 1));
      chk($sformatf("%s_rdy%0d", tag, k), 32'(m_if.din_ready), 32'(k == nbits - 1));
      chk($sformatf("%s_busy%0d", tag, k), 32'(m_if.busy), 32'(k != nbits - 1));
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] code, input logic [15:0] exp);
    @(negedge clk);
    chk({tag, "_rdy_pre"}, 32'(m_if.din_ready), 1);
    m_if.din       = code;
    m_if.din_valid = 1'b1;
    @(posedge clk);
    capture(tag, exp, NB, -1, 8'h00, 1'b1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    m_if.din       = '0;
    m_if.din_valid = 1'b0;
    g_if.din       = '0;
    g_if.din_valid = 1'b0;

    repeat (5) begin
      @(negedge clk);
      chk_idle("in_rst");
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_idle($sformatf("idle%0d", i));
    end

    run_frame("a5", 8'hA5, V_A5);
    run_frame("h07", 8'h07, V_07);

    // valid held high across two frames, din changed mid-frame
    @(negedge clk);
    m_if.din       = 8'h3C;
    m_if.din_valid = 1'b1;
    @(posedge clk);
    capture("b2b1", V_3C, NB, 5, 8'hFF, 1'b0);
    @(posedge clk);
    capture("b2b2", V_FF, NB, -1, 8'h00, 1'b1);

    // asynchronous abort during data bit 3
    @(negedge clk);
    m_if.din       = 8'hFF;
    m_if.din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_if.din_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_pre_x", 32'(m_if.x), 1);
    chk("abort_pre_busy", 32'(m_if.busy), 1);
    #1 rst = 1'b1;
    #1 chk_idle("abort");
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", 8'hA5, V_A5);

    // GAP=0 instance: A5 then 3C with valid held through the second handshake
    @(negedge clk);
    chk("g0_rdy_pre", 32'(g_if.din_ready), 1);
    g_if.din       = 8'hA5;
    g_if.din_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= 2 * L + 2; c++) begin
      @(negedge clk);
      if (c == 1) g_if.din = 8'h3C;
      if (c == L + 1) g_if.din_valid = 1'b0;
      if (c > 0)
        chk($sformatf("g0_x%0d", c), 32'(g_if.x), 32'(V_G0[2*L+2-c]));
      chk($sformatf("g0_done%0d", c), 32'(g_if.frame_done), 32'(c == L || c == 2 * L + 1));
      chk($sformatf("g0_rdy%0d", c), 32'(g_if.din_ready), 32'(c == L || c >= 2 * L + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
